// File: rtl/count_sched.sv
// count_sched: round-robin two-requester burst scheduler driving a shared 8-bit up/down counter
// Ports: clk/clr (async active-high reset), req/req_dir/len0/len1 from requesters,
//   gnt/ack/err back to requesters, busy status, cnt_en/cnt_updown to the counter,
//   cnt_c wrap flag from the counter, wraps = saturating wrap-event count.
// Build option: define COUNT_SCHED_WRAP_STOP_EN to end a burst early (err=1) on a wrap seen in RUN.
module count_sched (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic [1:0] req_dir,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic       err,
  output logic       busy,
  output logic       cnt_en,
  output logic       cnt_updown,
  input  logic       cnt_c,
  output logic [7:0] wraps
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic rr, dir, en_d, wrap_ev, stop, pick;
  logic [1:0] gnt_n;
  logic [7:0] rem, len_w;
  assign pick = (req == 2'b11) ? rr : req[1];
  assign gnt_n = pick ? 2'b10 : 2'b01;
  assign len_w = pick ? len1 : len0;
  // cnt_c only means a wrap in the cycle right after a step
  assign wrap_ev = en_d & cnt_c;
`ifdef COUNT_SCHED_WRAP_STOP_EN
  assign stop = wrap_ev & (state == RUN);
`else
  assign stop = 1'b0;
`endif
  always_ff @(posedge clk or posedge clr)
    if (clr) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = (state == IDLE) ? ((|req) ? ((len_w == 8'd0) ? DONE : RUN) : IDLE) :
          (state == RUN)  ? ((stop || rem == 8'd1) ? DONE : RUN) : IDLE;
  end
  always_comb begin
    cnt_en = (state == RUN) & ~stop;
    cnt_updown = (state == RUN) & dir;
    busy = (state != IDLE);
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      rr <= 1'b0;
      dir <= 1'b0;
      en_d <= 1'b0;
      rem <= 8'd0;
      gnt <= 2'b00;
      ack <= 2'b00;
      err <= 1'b0;
      wraps <= 8'd0;
    end else begin
      rr <= (state == DONE) ? ~rr : rr;
      dir <= (state == IDLE) ? req_dir[pick] : dir;
      en_d <= cnt_en;
      rem <= (state == IDLE) ? len_w : rem - {7'd0, state == RUN};
      gnt <= (state == IDLE && |req) ? gnt_n : (state == DONE) ? 2'b00 : gnt;
      ack <= (nxt == DONE) ? ((state == IDLE) ? gnt_n : gnt) : 2'b00;
      err <= stop;
      wraps <= wraps + {7'd0, wrap_ev & (wraps != 8'hFF)};
    end
endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: randomized scoreboard bench for count_sched with a behavioural counter and burst model
module tb_count_sched;
  logic clk = 1'b0, clr = 1'b1;
  logic [1:0] req = '0, req_dir = '0, gnt, ack;
  logic [7:0] len0 = '0, len1 = '0, wraps;
  logic err, busy, cnt_en, cnt_updown, cnt_c = 1'b0;
  logic [7:0] cnt = 8'h00, ld_v = 8'h00;
  logic ld = 1'b0;
  int n_cmp = 0, n_bad = 0;

  count_sched dut (.clk(clk), .clr(clr), .req(req), .req_dir(req_dir), .len0(len0), .len1(len1),
    .gnt(gnt), .ack(ack), .err(err), .busy(busy), .cnt_en(cnt_en), .cnt_updown(cnt_updown),
    .cnt_c(cnt_c), .wraps(wraps));

  always #5 clk = ~clk;

  // the shared counter the scheduler drives; cnt_c flags a wrap in the cycle after the step
  always @(posedge clk) begin
    if (ld) begin
      cnt <= ld_v;
      cnt_c <= 1'b0;
    end else if (cnt_en) begin
      cnt <= cnt_updown ? cnt + 8'd1 : cnt - 8'd1;
      cnt_c <= cnt_updown ? (cnt == 8'hFF) : (cnt == 8'h00);
    end else cnt_c <= 1'b0;
  end

  typedef struct {
    logic [1:0] who;
    int steps, ups, lat, wraps;
    logic err;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb[$];
  int rr_m = 0, wraps_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_cnt_en"}, 32'(cnt_en), 0);
    chk({tag, "_cnt_updown"}, 32'(cnt_updown), 0);
    chk({tag, "_wraps"}, 32'(wraps), 0);
  endtask

  // monitor: counts steps between completions and checks each ack against the scoreboard
  int cyc = 0, g_cyc = 0, steps = 0, ups = 0, pend_wv = 0;
  bit pend_w = 0;
  logic [1:0] prev_g = '0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (clr) begin
      steps = 0;
      ups = 0;
      pend_w = 0;
      prev_g = '0;
    end else begin
      if (pend_w) begin
        chk("wraps", 32'(wraps), 32'(pend_wv));
        pend_w = 0;
      end
      if (gnt != 2'b00 && prev_g == 2'b00) g_cyc = cyc;
      prev_g = gnt;
      if (cnt_en) begin
        steps++;
        if (cnt_updown) ups++;
      end
      if (ack != 2'b00) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ack: got ack=%b expected none", ack);
        end else begin
          e = sb.pop_front();
          chk("ack_who", 32'(ack), 32'(e.who));
          chk("gnt_with_ack", 32'(gnt), 32'(e.who));
          chk("busy_at_ack", 32'(busy), 1);
          chk("steps", 32'(steps), 32'(e.steps));
          chk("up_steps", 32'(ups), 32'(e.ups));
          chk("err", 32'(err), 32'(e.err));
          chk("latency", 32'(cyc - g_cyc), 32'(e.lat));
          chk("counter_end", 32'(cnt), 32'(e.cnt));
          pend_w = 1;
          pend_wv = e.wraps;
        end
        steps = 0;
        ups = 0;
      end
    end
  end

  task automatic preload(input logic [7:0] v);
    ld_v = v;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // reference: a burst of L steps from v wraps at most once, at step k
  task automatic burst(input logic [1:0] r, input logic [7:0] l0, input logic [7:0] l1, input logic [1:0] d);
    exp_t e;
    int w, v, L, k, up;
    bit wr, st, got;
    v = int'(cnt);
    w = (r == 2'b11) ? rr_m : (r[1] ? 1 : 0);
    L = w ? int'(l1) : int'(l0);
    up = int'(d[w]);
    k = up ? 256 - v : v + 1;
    wr = (k <= L);
`ifdef COUNT_SCHED_WRAP_STOP_EN
    st = wr && (k < L);
`else
    st = 1'b0;
`endif
    e.who = w ? 2'b10 : 2'b01;
    e.steps = st ? k : L;
    e.ups = up ? e.steps : 0;
    e.lat = st ? k + 1 : L;
    e.err = st;
    e.cnt = 8'((up ? v + e.steps : v - e.steps + 256) % 256);
    wraps_m = (wraps_m + int'(wr) > 255) ? 255 : wraps_m + int'(wr);
    e.wraps = wraps_m;
    sb.push_back(e);
    req_dir = d;
    len0 = l0;
    len1 = l1;
    req = r;
    got = 0;
    for (int i = 0; i < 700 && !got; i++) begin
      @(negedge clk);
      got = |ack;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: got no ack expected ack=%b", e.who);
    end
    req = 2'b00;
    rr_m = 1 - rr_m;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] a, b;
    repeat (3) @(negedge clk);
    check_zero("reset");
    clr = 1'b0;
    @(negedge clk);
    burst(2'b11, 8'd3, 8'd4, 2'b11);
    burst(2'b11, 8'd3, 8'd4, 2'b10);
    burst(2'b11, 8'd2, 8'd1, 2'b01);
    burst(2'b11, 8'd2, 8'd1, 2'b00);
    burst(2'b01, 8'd5, 8'd0, 2'b01);
    burst(2'b10, 8'd7, 8'd0, 2'b00);
    burst(2'b11, 8'd0, 8'd0, 2'b00);
    preload(8'hFE);
    burst(2'b01, 8'd4, 8'd0, 2'b01);
    preload(8'h01);
    burst(2'b10, 8'd0, 8'd5, 2'b00);
    preload(8'hFF);
    burst(2'b01, 8'd255, 8'd0, 2'b01);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0)
        preload($urandom_range(0, 2) == 0 ? 8'($urandom_range(0, 255)) :
                $urandom_range(0, 1) == 0 ? 8'($urandom_range(0, 6)) : 8'($urandom_range(249, 255)));
      a = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 30));
      burst(2'($urandom_range(1, 3)), a, b, 2'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 258; i++) begin
      preload(8'hFF);
      burst(2'b01, 8'd1, 8'd0, 2'b01);
    end
    @(negedge clk);
    preload(8'h40);
    req_dir = 2'b01;
    len0 = 8'd10;
    req = 2'b01;
    repeat (4) @(negedge clk);
    chk("mid_run_cnt_en", 32'(cnt_en), 1);
    chk("mid_run_gnt", 32'(gnt), 1);
    clr = 1'b1;
    req = 2'b00;
    @(negedge clk);
    check_zero("clr_mid");
    clr = 1'b0;
    rr_m = 0;
    wraps_m = 0;
    repeat (2) @(negedge clk);
    burst(2'b11, 8'd2, 8'd3, 2'b01);
    burst(2'b11, 8'd2, 8'd3, 2'b01);
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
